// File: rtl/cla_pkg.sv
// Shared constants and term-group geometry for the decomposed CLA adder
// (nonlinear_part produces the terms, linear_part_pipe recombines them).
package cla_pkg;

    localparam int unsigned NBIT_DEF = 4;

    // Carry c_(i+1) expands to 2^(i+2)-1 product terms.
    function automatic int unsigned grp_len(input int unsigned i);
        return (32'd1 << (i + 32'd2)) - 32'd1;
    endfunction

    function automatic int unsigned grp_off(input int unsigned i);
        int unsigned off;
        off = 0;
        for (int unsigned k = 0; k < i; k++) begin
            off += grp_len(k);
        end
        return off;
    endfunction

    function automatic int unsigned nnl(input int unsigned nbit);
        return (32'd1 << (nbit + 32'd2)) - nbit - 32'd4;
    endfunction

endpackage

// File: rtl/cla_pipe_reg.sv
// One pipeline stage: data register plus valid bit. Load wins over drain;
// data is written only on load so idle inputs never reach the register.
module cla_pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/linear_part_pipe.sv
// Linear half of the decomposed CLA adder: XOR-recombines nonlinear terms into
// carries and sum bits behind a two-stage valid/ready pipeline.
module linear_part_pipe
    import cla_pkg::*;
#(
    parameter int unsigned NBIT = NBIT_DEF,
    parameter int unsigned NNL  = nnl(NBIT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c,
    input  logic [NNL-1:0]  n,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] s,
    output logic            cout
);

    localparam int unsigned W1 = NBIT + 1 + NNL;
    localparam int unsigned W2 = NBIT + 1;

    if (NBIT < 1 || NNL != nnl(NBIT)) begin : g_bad_param
        $error("linear_part_pipe: NNL must equal 2^(NBIT+2)-NBIT-4 with NBIT >= 1");
    end

    logic            v1, v2, en2, acc;
    logic [W1-1:0]   s1_d, s1_q;
    logic [W2-1:0]   s2_d, s2_q;
    logic [NBIT-1:0] p1;
    logic [NNL-1:0]  n1;
    logic [NBIT:0]   carry;

    assign en2      = !v2 | out_ready;
    assign in_ready = !rst & (!v1 | en2);
    assign acc      = in_valid & in_ready;
    assign s1_d     = {a ^ b, c, n};

    cla_pipe_reg #(
        .W(W1)
    ) u_stage1 (
        .clk  (clk),
        .rst  (rst),
        .load (acc),
        .drain(v1 & en2),
        .d    (s1_d),
        .q    (s1_q),
        .valid(v1)
    );

    assign p1       = s1_q[W1-1 -: NBIT];
    assign carry[0] = s1_q[NNL];
    assign n1       = s1_q[NNL-1:0];

    // Each carry is the parity of its own term group; no AND past stage 1.
    for (genvar i = 0; i < NBIT; i++) begin : g_grp
        localparam int unsigned Off = grp_off(i);
        localparam int unsigned Len = grp_len(i);
        assign carry[i+1] = ^n1[Off +: Len];
    end

    assign s2_d = {carry[NBIT], p1 ^ carry[NBIT-1:0]};

    cla_pipe_reg #(
        .W(W2)
    ) u_stage2 (
        .clk  (clk),
        .rst  (rst),
        .load (v1 & en2),
        .drain(out_ready),
        .d    (s2_d),
        .q    (s2_q),
        .valid(v2)
    );

    assign out_valid = v2;
    assign s         = s2_q[NBIT-1:0];
    assign cout      = s2_q[NBIT];

endmodule

// File: tb/tb_linear_part_pipe.sv
// Scoreboard bench for linear_part_pipe: expected {cout,s} = a+b+c pushed on
// accept, popped and compared by an independent output monitor.
module tb_linear_part_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        c = 1'b0;
    logic [55:0] n = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  s;
    logic        cout;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_in = 0;
    int unsigned n_out = 0;
    int unsigned n_drop = 0;
    int unsigned rdy_pct = 100;
    logic [4:0]  exp_q[$];
    logic        hold_chk = 1'b0;
    logic [4:0]  held = '0;

    linear_part_pipe #(
        .NBIT(4),
        .NNL (56)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .n        (n),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ANF product terms of each carry: c_(i+1) = a_i b_i ^ a_i*c_i ^ b_i*c_i, expanded.
    function automatic logic [55:0] gen_terms(input logic [3:0] ta, input logic [3:0] tb,
                                              input logic tc);
        logic [55:0] v;
        logic        t[$];
        logic        nt[$];
        int          pos;
        v   = '0;
        pos = 0;
        t   = {tc};
        for (int i = 0; i < 4; i++) begin
            nt = {};
            nt.push_back(ta[i] & tb[i]);
            foreach (t[k]) nt.push_back(ta[i] & t[k]);
            foreach (t[k]) nt.push_back(tb[i] & t[k]);
            foreach (nt[k]) begin
                v[pos] = nt[k];
                pos++;
            end
            t = nt;
        end
        return v;
    endfunction

    // Random terms whose group parities still equal the true carries.
    function automatic logic [55:0] gen_rand(input logic [3:0] ta, input logic [3:0] tb,
                                             input logic tc);
        logic [55:0] v;
        int          off;
        v   = '0;
        off = 0;
        for (int i = 0; i < 4; i++) begin
            int   len;
            int   m;
            int   cy;
            logic par;
            len = (4 << i) - 1;
            m   = (2 << i) - 1;
            cy  = ((int'(ta) & m) + (int'(tb) & m) + int'(tc)) >> (i + 1);
            par = 1'b0;
            for (int k = 0; k < len - 1; k++) begin
                v[off+k] = 1'($urandom_range(1));
                par ^= v[off+k];
            end
            v[off+len-1] = par ^ cy[0];
            off += len;
        end
        return v;
    endfunction

    function automatic logic [4:0] model(input logic [3:0] ta, input logic [3:0] tb,
                                         input logic tc);
        int sum;
        sum = int'(ta) + int'(tb) + int'(tc);
        return sum[4:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                        input logic [55:0] tn, input logic [4:0] texp);
        int  waited;
        logic ok;
        waited = 0;
        ok     = 1'b0;
        a = ta; b = tb; c = tc; n = tn;
        in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
            end else begin
                waited++;
                if (waited > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
                    break;
                end
            end
        end
        if (ok) begin
            exp_q.push_back(texp);
            n_in++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 600) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst) begin
            if (hold_chk) begin
                check("stall_hold", {26'd0, out_valid, cout, s}, {26'd0, 1'b1, held});
            end
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got s=%h cout=%b, expected no output",
                             s, cout);
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, s} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got s=%h cout=%b, expected s=%h cout=%b",
                                 s, cout, e[3:0], e[4]);
                    end
                end
            end
        end
        hold_chk = !rst && out_valid && !out_ready;
        held     = {cout, s};
    end

    initial begin
        logic [3:0] ra, rb;
        logic       rc;

        // Reset state
        @(negedge clk);
        check("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {26'd0, out_valid, cout, s}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single op latency
        rdy_pct = 100;
        idle(2);
        send(4'hF, 4'h1, 1'b0, gen_terms(4'hF, 4'h1, 1'b0), model(4'hF, 4'h1, 1'b0));
        @(negedge clk);
        check("latency_cycle1_invalid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_cycle2_valid", {31'd0, out_valid}, 32'd1);
        check("first_result", {27'd0, cout, s}, 32'h10);
        drain();

        // Back-to-back pair
        send(4'h5, 4'h3, 1'b1, gen_terms(4'h5, 4'h3, 1'b1), 5'h09);
        send(4'hA, 4'h5, 1'b1, gen_terms(4'hA, 4'h5, 1'b1), 5'h10);
        drain();

        // Exhaustive stream, random backpressure and bubbles
        rdy_pct = 50;
        for (int i = 0; i < 512; i++) begin
            ra = 4'(i);
            rb = 4'(i >> 4);
            rc = 1'(i >> 8);
            send(ra, rb, rc, gen_terms(ra, rb, rc), model(ra, rb, rc));
            if ($urandom_range(4) == 0) idle(1);
        end
        // Random operands with arbitrary term patterns of the right parity
        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rc = 1'($urandom_range(1));
            send(ra, rb, rc, gen_rand(ra, rb, rc), model(ra, rb, rc));
            if ($urandom_range(3) == 0) idle(1);
        end
        rdy_pct = 100;
        drain();

        // Stall: out_ready held low, three ops offered
        rdy_pct = 0;
        idle(2);
        send(4'h1, 4'h2, 1'b0, gen_terms(4'h1, 4'h2, 1'b0), 5'h03);
        send(4'h7, 4'h9, 1'b1, gen_terms(4'h7, 4'h9, 1'b1), 5'h11);
        a = 4'hC; b = 4'hD; c = 1'b0; n = gen_terms(4'hC, 4'hD, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        rdy_pct = 100;
        send(4'hC, 4'hD, 1'b0, gen_terms(4'hC, 4'hD, 1'b0), 5'h19);
        drain();

        // Reset with both stages full
        rdy_pct = 0;
        idle(2);
        send(4'h3, 4'h3, 1'b0, gen_terms(4'h3, 4'h3, 1'b0), 5'h06);
        send(4'h8, 4'h8, 1'b1, gen_terms(4'h8, 4'h8, 1'b1), 5'h11);
        rst = 1'b1;
        n_drop += 32'(exp_q.size());
        exp_q.delete();
        @(negedge clk);
        check("in_ready_mid_rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_pct = 100;
        @(negedge clk);
        check("post_rst_outputs", {26'd0, out_valid, cout, s}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(6);

        // Linearity: single forced terms with all-zero operands
        send(4'h0, 4'h0, 1'b0, 56'd1 << 25, 5'h10);
        send(4'h0, 4'h0, 1'b0, 56'd1, 5'h02);
        drain();

        check("ops_in_eq_out", n_in, n_out + n_drop);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
